// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ping/pong frame buffer that collects a stream of complex
// samples into frames of N = 2^STAGE entries and replays each completed frame
// to an FFT core as N back-to-back indexed samples with a start pulse.
// imode (latched on sample 0 of a frame) conjugates the frame on entry.
// Optional build macro: FFT_FEEDER_BITREV_EN -- when defined, the sample
// presented at oaddr = k is the stored sample at bit-reversed index k.
module fft_frame_feeder #(
    parameter int STAGE = 6,
    parameter int RW    = 16,
    parameter int IW    = 16
) (
    input  logic             iclk,
    input  logic             rst_n,
    input  logic [RW-1:0]    iReal,
    input  logic [IW-1:0]    iImag,
    input  logic             ivalid,
    output logic             iready,
    input  logic             imode,
    output logic [RW-1:0]    oReal,
    output logic [IW-1:0]    oImag,
    output logic [STAGE-1:0] oaddr,
    output logic             oen,
    output logic             ostart
);

    localparam int N  = 1 << STAGE;
    localparam int DW = RW + IW;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Two's-complement negate; the most negative value saturates to max positive.
    function automatic logic [IW-1:0] neg_sat(input logic [IW-1:0] v);
        logic [IW-1:0] min_v;
        min_v = {1'b1, {(IW-1){1'b0}}};
        if (v == min_v) begin
            neg_sat = {1'b0, {(IW-1){1'b1}}};
        end else begin
            neg_sat = ~v + {{(IW-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef FFT_FEEDER_BITREV_EN
    // Mirror the STAGE index bits.
    function automatic logic [STAGE-1:0] bitrev(input logic [STAGE-1:0] k);
        for (int b = 0; b < STAGE; b++) begin
            bitrev[b] = k[STAGE-1-b];
        end
    endfunction
`endif

    // Storage: bank select is the MSB of the address.
    logic [DW-1:0]    mem_r [0:2*N-1];

    // Write side state
    logic             wr_bank_r;
    logic [STAGE-1:0] wr_idx_r;
    logic             mode_r;
    logic [1:0]       full_r;

    // Read side state
    state_t           state_r;
    state_t           state_s;
    logic             rd_bank_r;
    logic [STAGE-1:0] rd_idx_r;

    logic             accept_s;
    logic             mode_eff_s;
    logic [IW-1:0]    wr_imag_s;
    logic [1:0]       set_s;
    logic [1:0]       clr_s;
    logic             rd_last_s;
    logic             other_ready_s;
    logic [STAGE-1:0] rd_addr_s;

    assign iready   = ~full_r[wr_bank_r];
    assign accept_s = ivalid & iready;

    // Write-path decode: effective mode, stored imaginary, bank set/clear strobes.
    always_comb begin
        set_s = 2'b00;
        clr_s = 2'b00;
        if (wr_idx_r == {STAGE{1'b0}}) begin
            mode_eff_s = imode;
        end else begin
            mode_eff_s = mode_r;
        end
        if (mode_eff_s) begin
            wr_imag_s = neg_sat(iImag);
        end else begin
            wr_imag_s = iImag;
        end
        rd_last_s = (state_r == PLAY) && (rd_idx_r == {STAGE{1'b1}});
        if (accept_s && (wr_idx_r == {STAGE{1'b1}})) begin
            set_s[wr_bank_r] = 1'b1;
        end else begin
            set_s = 2'b00;
        end
        if (rd_last_s) begin
            clr_s[rd_bank_r] = 1'b1;
        end else begin
            clr_s = 2'b00;
        end
        // A frame completing on this very edge counts as ready, so playback
        // can continue into it without a gap cycle.
        other_ready_s = full_r[~rd_bank_r] | set_s[~rd_bank_r];
`ifdef FFT_FEEDER_BITREV_EN
        rd_addr_s = bitrev(rd_idx_r);
`else
        rd_addr_s = rd_idx_r;
`endif
    end

    // Sample storage; contents survive reset on purpose (only flags are cleared).
    always_ff @(posedge iclk) begin
        if (accept_s) begin
            mem_r[{wr_bank_r, wr_idx_r}] <= {iReal, wr_imag_s};
        end
    end

    // Write index, write bank pointer and per-frame mode latch.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r  <= {STAGE{1'b0}};
            wr_bank_r <= 1'b0;
            mode_r    <= 1'b0;
        end else if (accept_s) begin
            wr_idx_r <= wr_idx_r + {{(STAGE-1){1'b0}}, 1'b1};
            if (wr_idx_r == {STAGE{1'b0}}) begin
                mode_r <= imode;
            end
            if (wr_idx_r == {STAGE{1'b1}}) begin
                wr_bank_r <= ~wr_bank_r;
            end
        end
    end

    // Bank full flags: release and completion on the same edge both apply.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r & ~clr_s) | set_s;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (full_r[rd_bank_r]) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (rd_last_s && !other_ready_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = PLAY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read index/bank and registered, mutually aligned frame outputs.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_r  <= {STAGE{1'b0}};
            rd_bank_r <= 1'b0;
            oen       <= 1'b0;
            ostart    <= 1'b0;
            oaddr     <= {STAGE{1'b0}};
            oReal     <= {RW{1'b0}};
            oImag     <= {IW{1'b0}};
        end else if (state_r == PLAY) begin
            oen              <= 1'b1;
            ostart           <= (rd_idx_r == {STAGE{1'b0}});
            oaddr            <= rd_idx_r;
            {oReal, oImag}   <= mem_r[{rd_bank_r, rd_addr_s}];
            rd_idx_r         <= rd_idx_r + {{(STAGE-1){1'b0}}, 1'b1};
            if (rd_last_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
        end else begin
            rd_idx_r <= {STAGE{1'b0}};
            oen      <= 1'b0;
            ostart   <= 1'b0;
            oaddr    <= {STAGE{1'b0}};
            oReal    <= {RW{1'b0}};
            oImag    <= {IW{1'b0}};
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed, table-driven bench for fft_frame_feeder with STAGE=3 (N=8).
module tb_fft_frame_feeder;

    localparam int STAGE = 3;
    localparam int N     = 8;

    logic        iclk   = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] iReal  = 16'h0000;
    logic [15:0] iImag  = 16'h0000;
    logic        ivalid = 1'b0;
    logic        imode  = 1'b0;
    logic        iready;
    logic [15:0] oReal;
    logic [15:0] oImag;
    logic [2:0]  oaddr;
    logic        oen;
    logic        ostart;

    fft_frame_feeder #(.STAGE(STAGE), .RW(16), .IW(16)) dut (
        .iclk   (iclk),
        .rst_n  (rst_n),
        .iReal  (iReal),
        .iImag  (iImag),
        .ivalid (ivalid),
        .iready (iready),
        .imode  (imode),
        .oReal  (oReal),
        .oImag  (oImag),
        .oaddr  (oaddr),
        .oen    (oen),
        .ostart (ostart)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        mode;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
    } vec_t;

    typedef struct {
        int          c;
        logic [2:0]  addr;
        logic        start;
        logic [15:0] re;
        logic [15:0] im;
    } cap_t;

    vec_t tbl [24];
    int   perm [8];
    cap_t cap_q [$];
    int   acc_edge [24];
    int   checks    = 0;
    int   errors    = 0;
    int   idle_bad  = 0;
    int   stalls    = 0;
    int   stall_idx = -1;

    // Output monitor: log every valid sample, flag non-zero idle outputs.
    always @(negedge iclk) begin
        if (oen) begin
            cap_q.push_back('{cyc, oaddr, ostart, oReal, oImag});
        end else if (oaddr != 3'd0 || oReal != 16'd0 || oImag != 16'd0 || ostart != 1'b0) begin
            idle_bad++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int w;
            w = 0;
            @(negedge iclk);
            iReal  = tbl[i].re;
            iImag  = tbl[i].im;
            imode  = tbl[i].mode;
            ivalid = 1'b1;
            while (!iready && w < 50) begin
                stalls++;
                stall_idx = i;
                @(negedge iclk);
                w++;
            end
            if (w >= 50) begin
                chk($sformatf("accept_timeout_%0d", i), 32'(w), 32'd0);
            end
            acc_edge[i] = cyc + 1;
        end
        @(negedge iclk);
        ivalid = 1'b0;
        imode  = 1'b0;
    endtask

    task automatic wait_cap(input int n);
        int w;
        w = 0;
        while (cap_q.size() < n && w < 300) begin
            @(negedge iclk);
            w++;
        end
        chk("frame_arrival", 32'(cap_q.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input int base, input int nf);
        for (int j = 0; j < nf * N && j < cap_q.size(); j++) begin
            int f;
            int k;
            f = j / N;
            k = j % N;
            chk($sformatf("oaddr_%0d", j), 32'(cap_q[j].addr), 32'(k));
            chk($sformatf("ostart_%0d", j), 32'(cap_q[j].start), 32'(k == 0));
            chk($sformatf("oReal_%0d", j), 32'(cap_q[j].re), 32'(tbl[base + f*N + perm[k]].exp_re));
            chk($sformatf("oImag_%0d", j), 32'(cap_q[j].im), 32'(tbl[base + f*N + perm[k]].exp_im));
            if (j > 0) begin
                chk($sformatf("contig_%0d", j), 32'(cap_q[j].c), 32'(cap_q[0].c + j));
            end
        end
    endtask

    initial begin
        logic [15:0] b_exp_im [8];
        int w;

        // Frame A: re=k, im=10+k; a stray imode=1 mid-frame must be ignored.
        // Frame B: imode=1 on sample 0 only, sample 3 im=0x8000 saturates.
        // Frame C: plain forward data.
        b_exp_im = '{16'hFFF6, 16'hFFF5, 16'hFFF4, 16'h7FFF,
                     16'hFFF2, 16'hFFF1, 16'hFFF0, 16'hFFEF};
        for (int k = 0; k < 8; k++) begin
            tbl[k]      = '{16'(k), 16'(10 + k), (k == 5), 16'(k), 16'(10 + k)};
            tbl[8 + k]  = '{16'(20 + k), (k == 3) ? 16'h8000 : 16'(10 + k), (k == 0),
                            16'(20 + k), b_exp_im[k]};
            tbl[16 + k] = '{16'(100 + k), 16'(16'hFFF0 - k), 1'b0, 16'(100 + k), 16'(16'hFFF0 - k)};
        end
`ifdef FFT_FEEDER_BITREV_EN
        perm = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        perm = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

        // Reset state.
        #3;
        chk("rst_oen", 32'(oen), 32'd0);
        chk("rst_ostart", 32'(ostart), 32'd0);
        chk("rst_oaddr", 32'(oaddr), 32'd0);
        chk("rst_oReal", 32'(oReal), 32'd0);
        chk("rst_oImag", 32'(oImag), 32'd0);
        chk("rst_iready", 32'(iready), 32'd1);
        @(negedge iclk);
        rst_n = 1'b1;

        // Single forward frame with latency check.
        cap_q.delete();
        stalls = 0;
        drive(0, 7);
        wait_cap(8);
        check_frames(0, 1);
        if (cap_q.size() > 0) chk("latency_a", 32'(cap_q[0].c), 32'(acc_edge[7] + 2));
        chk("stalls_a", 32'(stalls), 32'd0);
        repeat (4) @(negedge iclk);

        // Inverse-mode frame with saturation.
        cap_q.delete();
        drive(8, 15);
        wait_cap(8);
        check_frames(8, 1);
        if (cap_q.size() > 0) chk("latency_b", 32'(cap_q[0].c), 32'(acc_edge[15] + 2));
        repeat (4) @(negedge iclk);

        // Three frames streamed continuously: both banks fill while frame 1
        // plays, so sample 16 waits exactly one cycle for bank 0 release.
        cap_q.delete();
        stalls    = 0;
        stall_idx = -1;
        drive(0, 23);
        wait_cap(24);
        check_frames(0, 3);
        if (cap_q.size() > 0) chk("latency_c", 32'(cap_q[0].c), 32'(acc_edge[7] + 2));
        chk("stall_count", 32'(stalls), 32'd1);
        chk("stall_sample", 32'(stall_idx), 32'd16);
        repeat (4) @(negedge iclk);

        // Reset in the middle of playback.
        cap_q.delete();
        drive(0, 7);
        w = 0;
        while (!(oen && oaddr == 3'd4) && w < 100) begin
            @(negedge iclk);
            w++;
        end
        chk("reach_addr4", 32'(oen && oaddr == 3'd4), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oen", 32'(oen), 32'd0);
        chk("mid_rst_oaddr", 32'(oaddr), 32'd0);
        chk("mid_rst_oReal", 32'(oReal), 32'd0);
        chk("mid_rst_oImag", 32'(oImag), 32'd0);
        chk("mid_rst_iready", 32'(iready), 32'd1);
        @(negedge iclk);
        @(negedge iclk);
        rst_n = 1'b1;
        cap_q.delete();
        repeat (20) @(negedge iclk);
        chk("no_oen_after_rst", 32'(cap_q.size()), 32'd0);
        drive(16, 23);
        wait_cap(8);
        check_frames(16, 1);
        if (cap_q.size() > 0) chk("latency_d", 32'(cap_q[0].c), 32'(acc_edge[23] + 2));
        repeat (4) @(negedge iclk);

        chk("idle_outputs_zero", 32'(idle_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
